// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared widths, FSM state type and address-field helpers for dcache
package dcache_pkg;

  localparam int ADDR_W   = 8;
  localparam int BYTE_W   = 8;
  localparam int TAG_W    = 3;
  localparam int INDEX_W  = 3;
  localparam int OFFSET_W = 2;
  localparam int BLOCK_W  = 32;
  localparam int MADDR_W  = TAG_W + INDEX_W;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FETCH,
    UPDATE
  } state_e;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W-1:0];
  endfunction

  function automatic logic [MADDR_W-1:0] block_addr(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:OFFSET_W];
  endfunction

  function automatic logic [BYTE_W-1:0] sel_byte(input logic [BLOCK_W-1:0] blk,
                                                 input logic [OFFSET_W-1:0] off);
    return blk[{off, 3'b000} +: BYTE_W];
  endfunction

endpackage

// File: rtl/dcache_if.sv
// rtl/dcache_if.sv - CPU load/store and block-memory signals of dcache
interface dcache_if;
  import dcache_pkg::*;

  logic                READ;
  logic                WRITE;
  logic [ADDR_W-1:0]   ADDRESS;
  logic [BYTE_W-1:0]   WRITEDATA;
  logic [BYTE_W-1:0]   READDATA;
  logic                BUSYWAIT;

  logic                MEM_READ;
  logic                MEM_WRITE;
  logic [MADDR_W-1:0]  MEM_ADDRESS;
  logic [BLOCK_W-1:0]  MEM_WRITEDATA;
  logic [BLOCK_W-1:0]  MEM_READDATA;
  logic                MEM_BUSYWAIT;

  // master is the surrounding system (CPU plus memory); slave is the cache
  modport master (
    output READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
    input  READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );

  modport slave (
    input  READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
    output READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );

endinterface

// File: rtl/dcache_array.sv
// rtl/dcache_array.sv - tag/valid/dirty/data storage, async read, sync byte-write and line-fill
module dcache_array
  import dcache_pkg::*;
#(
  parameter int BLOCKS      = 8,
  parameter int BLOCK_BYTES = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [INDEX_W-1:0]         index_i,
  output logic [TAG_W-1:0]           tag_o,
  output logic                       valid_o,
  output logic                       dirty_o,
  output logic [BLOCK_BYTES*8-1:0]   data_o,
  input  logic                       wr_en_i,
  input  logic [OFFSET_W-1:0]        wr_offset_i,
  input  logic [BYTE_W-1:0]          wr_byte_i,
  input  logic                       fill_en_i,
  input  logic [TAG_W-1:0]           fill_tag_i,
  input  logic [BLOCK_BYTES*8-1:0]   fill_data_i
);

  logic [BLOCKS-1:0]         valid_q;
  logic [BLOCKS-1:0]         dirty_q;
  logic [TAG_W-1:0]          tag_q  [BLOCKS];
  logic [BLOCK_BYTES*8-1:0]  data_q [BLOCKS];

  assign tag_o   = tag_q[index_i];
  assign valid_o = valid_q[index_i];
  assign dirty_o = dirty_q[index_i];
  assign data_o  = data_q[index_i];

  // a fill always lands clean; the store that caused a write miss retries afterwards as a hit
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      dirty_q <= '0;
      for (int i = 0; i < BLOCKS; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (fill_en_i) begin
      valid_q[index_i] <= 1'b1;
      dirty_q[index_i] <= 1'b0;
      tag_q[index_i]   <= fill_tag_i;
      data_q[index_i]  <= fill_data_i;
    end else if (wr_en_i) begin
      dirty_q[index_i]                              <= 1'b1;
      data_q[index_i][{wr_offset_i, 3'b000} +: 8]   <= wr_byte_i;
    end
  end

endmodule

// File: rtl/dcache.sv
// rtl/dcache.sv - direct-mapped write-back data cache: miss FSM, hit logic and output muxing
module dcache
  import dcache_pkg::*;
#(
  parameter int BLOCKS      = 8,
  parameter int BLOCK_BYTES = 4
) (
  input  logic     CLK,
  input  logic     RESET,
  dcache_if.slave  bus
);

  state_e              state_q, state_d;
  logic                first_q, first_d;
  logic [BLOCK_W-1:0]  fill_q, fill_d;
  logic [BYTE_W-1:0]   rdata_q, rdata_d;

  logic [TAG_W-1:0]    line_tag;
  logic                line_valid;
  logic                line_dirty;
  logic [BLOCK_W-1:0]  line_data;

  logic                req, hit, rd_hit, mem_done;
  logic [BYTE_W-1:0]   hit_byte;
  logic                busy, mem_read, mem_write, wr_en, fill_en;
  logic [MADDR_W-1:0]  mem_addr;
  logic [BLOCK_W-1:0]  mem_wdata;

  dcache_array #(
    .BLOCKS      (BLOCKS),
    .BLOCK_BYTES (BLOCK_BYTES)
  ) u_array (
    .clk_i       (CLK),
    .rst_ni      (RESET),
    .index_i     (addr_index(bus.ADDRESS)),
    .tag_o       (line_tag),
    .valid_o     (line_valid),
    .dirty_o     (line_dirty),
    .data_o      (line_data),
    .wr_en_i     (wr_en),
    .wr_offset_i (addr_offset(bus.ADDRESS)),
    .wr_byte_i   (bus.WRITEDATA),
    .fill_en_i   (fill_en),
    .fill_tag_i  (addr_tag(bus.ADDRESS)),
    .fill_data_i (fill_q)
  );

  assign req      = bus.READ | bus.WRITE;
  assign hit      = line_valid && (line_tag == addr_tag(bus.ADDRESS));
  assign hit_byte = sel_byte(line_data, addr_offset(bus.ADDRESS));
  assign rd_hit   = (state_q == IDLE) && bus.READ && !bus.WRITE && hit;
  // first_q blocks completion on the entry edge, giving memory one cycle to raise MEM_BUSYWAIT
  assign mem_done = !first_q && !bus.MEM_BUSYWAIT;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      first_q <= 1'b0;
      fill_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      fill_q  <= fill_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    first_d   = 1'b0;
    fill_d    = fill_q;
    rdata_d   = rd_hit ? hit_byte : rdata_q;
    busy      = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    wr_en     = 1'b0;
    fill_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            wr_en = bus.WRITE;
          end else begin
            busy    = 1'b1;
            first_d = 1'b1;
            state_d = (line_valid && line_dirty) ? WRITEBACK : FETCH;
          end
        end
      end
      WRITEBACK: begin
        busy      = 1'b1;
        mem_write = 1'b1;
        mem_addr  = {line_tag, addr_index(bus.ADDRESS)};
        mem_wdata = line_data;
        if (mem_done) begin
          first_d = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        busy     = 1'b1;
        mem_read = 1'b1;
        mem_addr = block_addr(bus.ADDRESS);
        if (mem_done) begin
          fill_d  = bus.MEM_READDATA;
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        busy    = 1'b1;
        fill_en = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state is already IDLE under reset, but an IDLE miss would still raise BUSYWAIT without this gate
  assign bus.BUSYWAIT      = busy & RESET;
  assign bus.READDATA      = rd_hit ? hit_byte : rdata_q;
  assign bus.MEM_READ      = mem_read;
  assign bus.MEM_WRITE     = mem_write;
  assign bus.MEM_ADDRESS   = mem_addr;
  assign bus.MEM_WRITEDATA = mem_wdata;

endmodule

// File: tb/tb_dcache.sv
// tb/tb_dcache.sv - directed self-checking bench for dcache with a latency-programmable memory
module tb_dcache;
  import dcache_pkg::*;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  dcache_if bus();

  dcache #(.BLOCKS(8), .BLOCK_BYTES(4)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  // memory: MEM_BUSYWAIT high for the first mem_lat cycles of each request, data from a fixed pattern
  int         mem_lat = 3;
  logic [1:0] kind_q  = 2'b00;
  int         cnt_q   = 0;
  int         eff;

  function automatic logic [31:0] mem_word(input logic [5:0] a);
    if (a == 6'd0) return 32'h44332211;
    return {2'b11, a, 2'b10, a, 2'b01, a, 2'b00, a};
  endfunction

  always_comb begin
    eff              = ({bus.MEM_READ, bus.MEM_WRITE} == kind_q) ? cnt_q : 0;
    bus.MEM_BUSYWAIT = (bus.MEM_READ | bus.MEM_WRITE) && (eff < mem_lat);
    bus.MEM_READDATA = mem_word(bus.MEM_ADDRESS);
  end

  always @(posedge CLK) begin
    kind_q <= {bus.MEM_READ, bus.MEM_WRITE};
    cnt_q  <= (bus.MEM_READ | bus.MEM_WRITE) ? eff + 1 : 0;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  int          stall, wb_cyc, fe_cyc;
  logic [5:0]  wb_addr, fe_addr;
  logic [31:0] wb_data;
  logic        both;

  // drives one request and samples at each negedge until BUSYWAIT falls (the hit cycle)
  task automatic access(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
    @(posedge CLK); #1;
    bus.READ = rd; bus.WRITE = wr; bus.ADDRESS = a; bus.WRITEDATA = d;
    stall = 0; wb_cyc = 0; fe_cyc = 0; wb_addr = 0; fe_addr = 0; wb_data = 0; both = 0;
    forever begin
      @(negedge CLK);
      if (bus.MEM_WRITE) begin wb_cyc++; wb_addr = bus.MEM_ADDRESS; wb_data = bus.MEM_WRITEDATA; end
      if (bus.MEM_READ) begin fe_cyc++; fe_addr = bus.MEM_ADDRESS; end
      if (bus.MEM_READ && bus.MEM_WRITE) both = 1'b1;
      if (!bus.BUSYWAIT) break;
      stall++;
      if (stall > 60) begin
        check("timeout", stall, 0);
        break;
      end
    end
  endtask

  initial begin
    RESET = 1'b0;
    bus.READ = 0; bus.WRITE = 0; bus.ADDRESS = 0; bus.WRITEDATA = 0;
    #12;
    check("rst_busywait", bus.BUSYWAIT, 0);
    check("rst_mem_read", bus.MEM_READ, 0);
    check("rst_mem_write", bus.MEM_WRITE, 0);
    check("rst_mem_addr", bus.MEM_ADDRESS, 0);
    check("rst_mem_wdata", bus.MEM_WRITEDATA, 0);
    check("rst_readdata", bus.READDATA, 0);
    bus.READ = 1'b1;
    #1;
    check("rst_busy_with_req", bus.BUSYWAIT, 0);
    bus.READ = 1'b0;
    #5 RESET = 1'b1;

    // clean read miss, L=3
    access(1, 0, 8'h00, 8'h00);
    check("miss0_stall", stall, 6);
    check("miss0_fetch_cyc", fe_cyc, 4);
    check("miss0_fetch_addr", fe_addr, 6'h00);
    check("miss0_no_wb", wb_cyc, 0);
    check("miss0_data", bus.READDATA, 8'h11);
    access(1, 0, 8'h03, 8'h00);
    check("hit3_stall", stall, 0);
    check("hit3_data", bus.READDATA, 8'h44);

    // dirty line then conflicting read: write-back before fetch
    access(1, 0, 8'h04, 8'h00);
    check("miss4_data", bus.READDATA, 8'h01);
    access(0, 1, 8'h05, 8'hAB);
    check("whit5_stall", stall, 0);
    access(1, 0, 8'h05, 8'h00);
    check("rhit5_stall", stall, 0);
    check("rhit5_data", bus.READDATA, 8'hAB);
    access(1, 0, 8'h25, 8'h00);
    check("dirty_stall", stall, 10);
    check("dirty_wb_cyc", wb_cyc, 4);
    check("dirty_wb_addr", wb_addr, 6'h01);
    check("dirty_wb_data", wb_data, 32'hC181AB01);
    check("dirty_fe_cyc", fe_cyc, 4);
    check("dirty_fe_addr", fe_addr, 6'h09);
    check("dirty_data", bus.READDATA, 8'h49);
    check("dirty_excl", both, 0);

    // write miss to clean line: fetch, then byte written, line left dirty
    access(0, 1, 8'h08, 8'h77);
    check("wmiss_stall", stall, 6);
    check("wmiss_no_wb", wb_cyc, 0);
    check("wmiss_fe_addr", fe_addr, 6'h02);
    access(1, 0, 8'h08, 8'h00);
    check("wmiss_rd0", bus.READDATA, 8'h77);
    access(1, 0, 8'h09, 8'h00);
    check("wmiss_rd1", bus.READDATA, 8'h42);
    access(1, 0, 8'h28, 8'h00);
    check("wmiss_evict_wb_addr", wb_addr, 6'h02);
    check("wmiss_evict_wb_data", wb_data, 32'hC2824277);
    check("wmiss_evict_fe_addr", fe_addr, 6'h0A);
    check("wmiss_evict_data", bus.READDATA, 8'h0A);

    // reset in the middle of a fetch
    @(posedge CLK); #1;
    bus.READ = 1; bus.WRITE = 0; bus.ADDRESS = 8'h30;
    @(negedge CLK);
    @(negedge CLK);
    check("midrst_pre_mem_read", bus.MEM_READ, 1);
    check("midrst_pre_addr", bus.MEM_ADDRESS, 6'h0C);
    #1 RESET = 1'b0;
    #1;
    check("midrst_mem_read", bus.MEM_READ, 0);
    check("midrst_busywait", bus.BUSYWAIT, 0);
    check("midrst_mem_addr", bus.MEM_ADDRESS, 0);
    check("midrst_readdata", bus.READDATA, 0);
    bus.READ = 0;
    @(negedge CLK);
    RESET = 1'b1;
    access(1, 0, 8'h30, 8'h00);
    check("postrst_stall", stall, 6);
    check("postrst_data", bus.READDATA, 8'h0C);

    // READ and WRITE together act as a write
    access(1, 0, 8'h10, 8'h00);
    check("rw_fill_no_wb", wb_cyc, 0);
    check("rw_fill_data", bus.READDATA, 8'h04);
    access(1, 1, 8'h10, 8'h5A);
    check("rw_stall", stall, 0);
    access(1, 0, 8'h10, 8'h00);
    check("rw_readback", bus.READDATA, 8'h5A);

    // zero-latency memory
    mem_lat = 0;
    access(1, 0, 8'h14, 8'h00);
    check("l0_stall", stall, 4);
    check("l0_fe_cyc", fe_cyc, 2);
    check("l0_data", bus.READDATA, 8'h05);
    @(posedge CLK); #1;
    bus.READ = 0; bus.WRITE = 0; bus.ADDRESS = 8'h00;
    @(negedge CLK);
    check("idle_hold_readdata", bus.READDATA, 8'h05);
    check("idle_busywait", bus.BUSYWAIT, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/dcache.md
# dcache

Direct-mapped, write-back data cache between the CPU's load/store path and the 32-bit-block data memory. On loads it supplies the byte that becomes the register file's write-data input. On stores it absorbs the register file's OUT1 value. It stalls the CPU through BUSYWAIT while a miss is serviced.

## Interface
Parameters:
- BLOCKS, 8, number of cache lines (index width 3)
- BLOCK_BYTES, 4, bytes per line (offset width 2)

Ports:
- CLK  in  1  system clock; all state changes on rising edge
- RESET  in  1  asynchronous, active-low reset
- READ  in  1  CPU load request, held until BUSYWAIT low
- WRITE  in  1  CPU store request, held until BUSYWAIT low
- ADDRESS  in  8  byte address: tag [7:5], index [4:2], offset [1:0]
- WRITEDATA  in  8  store byte
- READDATA  out  8  load byte, to register-file data input
- BUSYWAIT  out  1  CPU stall
- MEM_READ  out  1  block fetch request
- MEM_WRITE  out  1  block write-back request
- MEM_ADDRESS  out  6  block address {tag, index}
- MEM_WRITEDATA  out  32  victim block, byte 0 in [7:0]
- MEM_READDATA  in  32  fetched block
- MEM_BUSYWAIT  in  1  memory busy

## Operation
- Per line: valid, dirty, 3-bit tag, 32-bit data.
- hit = valid[index] & (tag[index] == ADDRESS[7:5]).
- States:
  - IDLE
  - WRITEBACK: MEM_WRITE=1, MEM_ADDRESS={old tag, index}, MEM_WRITEDATA=line data.
  - FETCH: MEM_READ=1, MEM_ADDRESS=ADDRESS[7:2].
  - UPDATE: line write; no memory request.
- IDLE, READ and hit:
  - READDATA = byte selected by offset, combinational.
  - BUSYWAIT=0.
- IDLE, WRITE and hit:
  - BUSYWAIT=0.
  - Next edge writes WRITEDATA into the selected byte and sets dirty.
- IDLE, (READ|WRITE) and miss:
  - BUSYWAIT=1 combinationally.
  - Next edge goes to WRITEBACK if valid&dirty, else to FETCH.
- WRITEBACK completes → FETCH.
- FETCH completes → UPDATE. The edge that leaves FETCH captures MEM_READDATA.
- UPDATE, one cycle: data and tag written, valid=1, dirty=0. Next edge returns to IDLE, where the request now hits.
- BUSYWAIT=1 in WRITEBACK, FETCH and UPDATE.
- READ and WRITE together: treated as WRITE.
- Neither asserted: no state change. READDATA holds the last driven value.

## Timing
- Memory handshake: a transaction completes on the first rising edge at which MEM_BUSYWAIT is sampled low, but no earlier than the second edge after entering the state. The memory therefore has one cycle to raise MEM_BUSYWAIT.
- MEM_READ/MEM_WRITE are Moore outputs. They drop in the cycle after completion. They are never asserted together.
- Read hit: 0 stall cycles.
- Write hit: 0 stall cycles; data visible to a read in the following cycle.
- Clean miss, memory latency L cycles (MEM_BUSYWAIT high L cycles): stall = 1 (IDLE) + max(L,1)+1 (FETCH) + 1 (UPDATE) cycles. BUSYWAIT falls in the IDLE hit cycle.
- Dirty miss: adds max(L,1)+1 cycles of WRITEBACK before FETCH.
- Reset asserted (RESET=0), any time, including mid-miss:
  - Immediately: state=IDLE, MEM_READ=0, MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0, READDATA=0.
  - All valid and dirty bits cleared; in-flight dirty data is discarded.
  - BUSYWAIT=0 while reset is held.
- Request inputs must stay stable while BUSYWAIT=1. Behaviour is undefined otherwise.

## Structure
- Package dcache_pkg: TAG_W=3, INDEX_W=3, OFFSET_W=2, BLOCK_W=32, the state enum (IDLE, WRITEBACK, FETCH, UPDATE), and address-field slice helpers.
- Sub-module dcache_array: tag, valid, dirty and data storage.
  - Asynchronous read.
  - Synchronous byte-write and line-fill ports.
  - Asynchronous clear on RESET.
- The top level holds the FSM, hit logic and output muxing.

## Test plan
- Reset then READ addr 0x00, memory returns 0x44332211 after L=3: BUSYWAIT high 6 cycles, MEM_ADDRESS=0x00, then READDATA=0x11. A follow-up READ 0x03 returns 0x44 with no stall.
- WRITE 0xAB to 0x05 (line 1 resident, tag 0): no stall, dirty set. Then READ 0x25, which maps to the same index with tag 1:
  - WRITEBACK with MEM_ADDRESS=0x01, MEM_WRITEDATA byte1=0xAB.
  - Then FETCH with MEM_ADDRESS=0x09.
- Write miss to clean line: fetch occurs, then the byte is written. The line is dirty and no write-back is issued.
- RESET low during FETCH: MEM_READ and BUSYWAIT drop at once. After release, READ of the same address misses again.
- READ and WRITE together, WRITE 0x5A to 0x10 on a hit: stored as a write. A subsequent READ 0x10 returns 0x5A.
- Memory with L=0 (MEM_BUSYWAIT never high): FETCH lasts exactly 2 cycles and the clean-miss stall is 4 cycles.
